fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 8 +
 rtl/retire_counter.sv | 16 +
 rtl/fetch_sequencer.sv | 66 ++++++
 tb/tb_fetch_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state encoding and program base addresses for the fetch sequencer.
package fetch_pkg;
    localparam int D = 10;
    localparam int A = 8;
    localparam int CW = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [D-1:0] PROG_BASE [4] = '{10'd0, 10'd128, 10'd256, 10'd384};
endpackage

// File: rtl/retire_counter.sv
// retire_counter: saturating retired-instruction counter with synchronous clear and enable.
module retire_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (en && !(&count)) count <= count + W'(1);
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs a selected program from its base and reports completion/fault/retire count.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic          branch_taken,
    input  logic [A-1:0]  branch_idx,
    input  logic          halt,
    input  logic          stall,
    output logic [A-1:0]  lut_addr,
    output logic          lut_branch,
    input  logic [D-1:0]  lut_target,
    output logic [D-1:0]  pc,
    output logic          running,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] retire_cnt
);
    state_t state;
    logic   active;
    logic   accept;
    assign active     = (state == RUN) && !stall;
    assign accept     = (state == IDLE) && start;
    assign lut_addr   = branch_idx;
    assign lut_branch = active && branch_taken;
    assign running    = state == RUN;
    assign done       = state == DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    pc    <= PROG_BASE[prog_sel];
                    fault <= 1'b0;
                end
                RUN: if (!stall) begin
                    if (halt) state <= DONE;
                    else if (branch_taken) pc <= lut_target;
                    else begin
                        pc <= pc + D'(1);
                        // Falling off the top of the address space ends the run as a fault
                        if (&pc) begin
                            fault <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: if (!start) state <= IDLE;
            endcase
        end
    end
    retire_counter #(.W(CW)) u_retire (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (active),
        .count (retire_cnt)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, reset/priority sequences and randomized run against a reference model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, branch_taken, halt, stall;
    logic [1:0]  prog_sel;
    logic [7:0]  branch_idx, lut_addr;
    logic [9:0]  lut_target, pc;
    logic        lut_branch, running, done, fault;
    logic [15:0] retire_cnt;
    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .branch_taken(branch_taken), .branch_idx(branch_idx), .halt(halt), .stall(stall),
        .lut_addr(lut_addr), .lut_branch(lut_branch), .lut_target(lut_target),
        .pc(pc), .running(running), .done(done), .fault(fault), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st; logic [1:0] sel; logic br; logic [7:0] idx; logic hl; logic sv; logic [9:0] tgt;
        logic lb; int epc; logic erun; logic edn; logic eft; int ecnt;
    } vec_t;
    vec_t vq[$];

    // Reference model: run/done flags plus integer PC and count
    bit m_run, m_done, m_fault;
    int m_pc, m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic st, input logic [1:0] sel, input logic br, input logic [7:0] idx,
                         input logic hl, input logic sv, input logic [9:0] tgt);
        start = st; prog_sel = sel; branch_taken = br; branch_idx = idx;
        halt = hl; stall = sv; lut_target = tgt;
    endtask

    task automatic check_regs(input string tag, input int epc, input logic erun, input logic edn,
                              input logic eft, input int ecnt);
        chk({tag, ".pc"}, 32'(pc), epc);
        chk({tag, ".running"}, 32'(running), 32'(erun));
        chk({tag, ".done"}, 32'(done), 32'(edn));
        chk({tag, ".fault"}, 32'(fault), 32'(eft));
        chk({tag, ".retire"}, 32'(retire_cnt), ecnt);
    endtask

    task automatic model_step(input logic st, input logic [1:0] sel, input logic br, input logic hl,
                              input logic sv, input int tgt);
        if (m_run) begin
            if (!sv) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                if (hl) begin m_run = 0; m_done = 1; end
                else if (br) m_pc = tgt;
                else if (m_pc + 1 > 1023) begin m_pc = 0; m_fault = 1; m_run = 0; m_done = 1; end
                else m_pc = m_pc + 1;
            end
        end else if (m_done) begin
            if (!st) m_done = 0;
        end else if (st) begin
            m_run = 1; m_pc = 128 * sel; m_cnt = 0; m_fault = 0;
        end
    endtask

    initial begin
        apply(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #12;
        check_regs("reset", 0, 0, 0, 0, 0);
        chk("reset.lut_branch", 32'(lut_branch), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;

        //          st sel br idx hl sv tgt   lb  pc  run dn ft cnt
        vq.push_back('{1, 1, 0, 3, 0, 0, 0,    0, 128, 1, 0, 0, 0});
        vq.push_back('{0, 1, 0, 4, 0, 0, 0,    0, 129, 1, 0, 0, 1});
        vq.push_back('{0, 0, 0, 5, 0, 0, 0,    0, 130, 1, 0, 0, 2});
        vq.push_back('{1, 2, 0, 6, 0, 0, 0,    0, 131, 1, 0, 0, 3});
        vq.push_back('{0, 0, 0, 7, 0, 0, 0,    0, 132, 1, 0, 0, 4});
        vq.push_back('{0, 0, 0, 8, 0, 0, 0,    0, 133, 1, 0, 0, 5});
        vq.push_back('{0, 0, 0, 9, 1, 0, 0,    0, 133, 0, 1, 0, 6});
        vq.push_back('{1, 3, 0, 0, 0, 0, 0,    0, 133, 0, 1, 0, 6});
        vq.push_back('{1, 3, 1, 0, 0, 0, 50,   0, 133, 0, 1, 0, 6});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0,    0, 133, 0, 0, 0, 6});
        vq.push_back('{1, 1, 0, 0, 0, 0, 0,    0, 128, 1, 0, 0, 0});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0,    0, 129, 1, 0, 0, 1});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0,    0, 130, 1, 0, 0, 2});
        vq.push_back('{0, 0, 1, 1, 0, 0, 20,   1, 20,  1, 0, 0, 3});
        vq.push_back('{0, 0, 1, 2, 1, 1, 99,   0, 20,  1, 0, 0, 3});
        vq.push_back('{0, 0, 1, 2, 1, 0, 99,   1, 20,  0, 1, 0, 4});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0,    0, 20,  0, 0, 0, 4});
        vq.push_back('{1, 3, 0, 0, 0, 0, 0,    0, 384, 1, 0, 0, 0});
        vq.push_back('{1, 0, 1, 9, 0, 0, 1023, 1, 1023, 1, 0, 0, 1});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0,    0, 0,   0, 1, 1, 2});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0,    0, 0,   0, 1, 1, 2});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0,    0, 0,   0, 0, 1, 2});
        vq.push_back('{1, 2, 0, 0, 0, 0, 0,    0, 256, 1, 0, 0, 0});
        vq.push_back('{1, 0, 0, 0, 1, 0, 0,    0, 256, 0, 1, 0, 1});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0,    0, 256, 0, 0, 0, 1});
        foreach (vq[i]) begin
            apply(vq[i].st, vq[i].sel, vq[i].br, vq[i].idx, vq[i].hl, vq[i].sv, vq[i].tgt);
            #3;
            chk($sformatf("row%0d.lut_branch", i), 32'(lut_branch), 32'(vq[i].lb));
            chk($sformatf("row%0d.lut_addr", i), 32'(lut_addr), 32'(vq[i].idx));
            @(posedge clk) #1;
            check_regs($sformatf("row%0d", i), vq[i].epc, vq[i].erun, vq[i].edn, vq[i].eft, vq[i].ecnt);
        end

        // Asynchronous reset in the middle of a run at PC=37
        apply(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk) #1;
        apply(0, 0, 1, 4, 0, 0, 37);
        @(posedge clk) #1;
        chk("midrun.pc_before", 32'(pc), 37);
        apply(0, 0, 1, 4, 0, 0, 5);
        #2 reset = 1'b1;
        #1;
        check_regs("midrun_reset", 0, 0, 0, 0, 0);
        chk("midrun_reset.lut_branch", 32'(lut_branch), 0);
        @(negedge clk) reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk) #1;
        check_regs("post_reset", 0, 0, 0, 0, 0);

        // Randomized run against the reference model
        m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            logic st, br, hl, sv;
            logic [1:0] sel;
            logic [7:0] idx;
            logic [9:0] tgt;
            st  = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom);
            br  = ($urandom_range(0, 3) == 0);
            hl  = ($urandom_range(0, 40) == 0);
            sv  = ($urandom_range(0, 4) == 0);
            idx = 8'($urandom);
            tgt = ($urandom_range(0, 1) == 1) ? 10'(1018 + $urandom_range(0, 5)) : 10'($urandom);
            apply(st, sel, br, idx, hl, sv, tgt);
            #3;
            chk("rand.lut_branch", 32'(lut_branch), 32'(br && m_run && !sv));
            chk("rand.lut_addr", 32'(lut_addr), 32'(idx));
            model_step(st, sel, br, hl, sv, int'(tgt));
            @(posedge clk) #1;
            check_regs("rand", m_pc, m_run, m_done, m_fault, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
